pwl_act_unit: RTL and testbench

PWL_ACT_UNIT -- requirements
Module: pwl_act_unit

---
 rtl/pwl_act_pkg.sv | 31 +++
 rtl/pwl_act_lane.sv | 76 +++++++
 rtl/pwl_act_unit.sv | 156 +++++++++++++++
 tb/tb_pwl_act_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwl_act_pkg.sv
// Shared definitions for the piecewise-linear activation unit.
// Holds the activation-mode encoding, the saturation-counter width and the
// constant functions that give the signed saturation limits for a width.
// Also supplies the default for the `WIDTH macro used as the WIDTH default.
`ifndef WIDTH
`define WIDTH 8
`endif

package pwl_act_pkg;

    localparam int unsigned MODE_W    = 2;
    localparam int unsigned SAT_CNT_W = 16;

    typedef enum logic [MODE_W-1:0] {
        ACT_EQ2   = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_HTANH = 2'd2,
        ACT_PASS  = 2'd3
    } act_mode_e;

    // Largest value representable in a w-bit two's-complement word.
    function automatic longint sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a w-bit two's-complement word.
    function automatic longint sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/pwl_act_lane.sv
// Per-channel second-stage math of the activation unit (purely combinational).
// Ports:
//   xp, xm  : x+ONE and x-ONE at 2*WIDTH+1 bits, registered by stage 1
//   mode    : activation function for this beat
//   res_c   : result saturated to the signed WIDTH range
//   sat_c   : set when the result had to be clipped
`ifndef WIDTH
`define WIDTH 8
`endif

module pwl_act_lane
    import pwl_act_pkg::*;
#(
    parameter int unsigned WIDTH = `WIDTH,
    parameter int unsigned FRAC  = 0
) (
    input  logic signed [2*WIDTH:0] xp,
    input  logic signed [2*WIDTH:0] xm,
    input  act_mode_e               mode,
    output logic        [WIDTH-1:0] res_c,
    output logic                    sat_c
);

    localparam int unsigned XW = 2 * WIDTH + 1;
    localparam int unsigned RW = XW + 1;

    localparam logic signed [XW-1:0] ONE_X = XW'(1) << FRAC;
    localparam logic signed [RW-1:0] ONE_R = RW'(ONE_X);
    localparam logic signed [RW-1:0] MAX_R = RW'(sat_max(WIDTH));
    localparam logic signed [RW-1:0] MIN_R = RW'(sat_min(WIDTH));

    logic signed [XW-1:0] x;
    logic        [XW-1:0] abs_p;
    logic        [XW-1:0] abs_m;
    logic        [XW-1:0] sum_u;
    logic signed [RW-1:0] x_e;
    logic signed [RW-1:0] r;

    // Function select followed by saturation to the output width.
    always_comb begin
        res_c = '0;
        sat_c = 1'b0;
        x     = xm + ONE_X;
        x_e   = RW'(x);
        // Magnitudes are non-negative, so the sum is kept unsigned: this is what
        // lets x = most-negative reach 2^(2*WIDTH) without wrapping.
        abs_p = xp[XW-1] ? (-xp) : xp;
        abs_m = xm[XW-1] ? (-xm) : xm;
        sum_u = abs_p + abs_m;
        r     = '0;
        case (mode)
            ACT_EQ2:   r = {2'b00, sum_u[XW-1:1]};
            ACT_RELU:  r = (!x[XW-1] && (x != '0)) ? x_e : '0;
            ACT_HTANH: begin
                if (x_e > ONE_R) begin
                    r = ONE_R;
                end else if (x_e < -ONE_R) begin
                    r = -ONE_R;
                end else begin
                    r = x_e;
                end
            end
            default:   r = x_e;
        endcase
        if (r > MAX_R) begin
            res_c = MAX_R[WIDTH-1:0];
            sat_c = 1'b1;
        end else if (r < MIN_R) begin
            res_c = MIN_R[WIDTH-1:0];
            sat_c = 1'b1;
        end else begin
            res_c = r[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pwl_act_unit.sv
// Two-stage pipelined piecewise-linear activation unit, CH channels per beat.
// Stage 1 registers x+ONE, x-ONE and the mode; stage 2 registers the lane
// results. Valid/ready on both sides, full throughput, no bubble on shift.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_data packs CH signed 2*WIDTH samples
//   in_mode             : function for the beat (EQ2, ReLU, hard-tanh, pass)
//   out_valid/out_ready : output handshake; out_data packs CH signed WIDTH results
//   out_sat             : per-channel saturation flags
// Optional (ACT_SAT_CNT_EN defined):
//   sat_clr             : zero the saturation counter (wins over increment)
//   sat_cnt             : count of output transfers with any out_sat bit set
`ifndef WIDTH
`define WIDTH 8
`endif

module pwl_act_unit
    import pwl_act_pkg::*;
#(
    parameter int unsigned WIDTH = `WIDTH,
    parameter int unsigned CH    = 4,
    parameter int unsigned FRAC  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH*2*WIDTH-1:0]   in_data,
    input  logic [MODE_W-1:0]       in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH*WIDTH-1:0]     out_data,
    output logic [CH-1:0]           out_sat
`ifdef ACT_SAT_CNT_EN
    ,
    input  logic                    sat_clr,
    output logic [SAT_CNT_W-1:0]    sat_cnt
`endif
);

    localparam int unsigned IW = 2 * WIDTH;
    localparam int unsigned XW = IW + 1;
    localparam logic [XW-1:0] ONE_X = XW'(1) << FRAC;

    logic                      s1_valid_q, s1_valid_d;
    logic [CH-1:0][XW-1:0]     s1_xp_q, s1_xp_d;
    logic [CH-1:0][XW-1:0]     s1_xm_q, s1_xm_d;
    act_mode_e                 s1_mode_q, s1_mode_d;
    logic                      s2_valid_q, s2_valid_d;
    logic [CH*WIDTH-1:0]       s2_data_q, s2_data_d;
    logic [CH-1:0]             s2_sat_q, s2_sat_d;
    logic [CH-1:0][WIDTH-1:0]  lane_res_c;
    logic [CH-1:0]             lane_sat_c;
    logic                      s2_take_c;
    logic                      in_fire_c;

    // Stage 2 can load when empty or draining; stage 1 likewise moves into it.
    assign s2_take_c = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_take_c;
    assign in_fire_c = in_valid && in_ready;

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_sat   = s2_sat_q;

    // Stage 1: widen each sample by one bit and form x +/- ONE without overflow.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_xp_d    = s1_xp_q;
        s1_xm_d    = s1_xm_q;
        s1_mode_d  = s1_mode_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_fire_c) begin
            s1_mode_d = act_mode_e'(in_mode);
            for (int c = 0; c < int'(CH); c++) begin
                s1_xp_d[c] = {in_data[c*IW+IW-1], in_data[c*IW +: IW]} + ONE_X;
                s1_xm_d[c] = {in_data[c*IW+IW-1], in_data[c*IW +: IW]} - ONE_X;
            end
        end
    end

    // Stage 2: capture lane results; data holds while stalled or on a bubble.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;
        if (s2_take_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = lane_res_c;
                s2_sat_d  = lane_sat_c;
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        pwl_act_lane #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC)
        ) u_lane (
            .xp    (s1_xp_q[c]),
            .xm    (s1_xm_q[c]),
            .mode  (s1_mode_q),
            .res_c (lane_res_c[c]),
            .sat_c (lane_sat_c[c])
        );
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_xp_q    <= '0;
            s1_xm_q    <= '0;
            s1_mode_q  <= ACT_EQ2;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_xp_q    <= s1_xp_d;
            s1_xm_q    <= s1_xm_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
        end
    end

`ifdef ACT_SAT_CNT_EN
    logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    // Sticky count of saturated output transfers; clear beats increment.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (s2_valid_q && out_ready && (|s2_sat_q) && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_pwl_act_unit.sv
// Scoreboard bench for pwl_act_unit (WIDTH=8, CH=4, FRAC=0).
// Stimulus pushes model results into a queue; a monitor pops on every output
// transfer. Build with ACT_SAT_CNT_EN defined to also exercise sat_cnt.
`timescale 1ns/1ps

module tb_pwl_act_unit;

    localparam int W    = 8;
    localparam int CH   = 4;
    localparam int FRAC = 0;
    localparam int IW   = 2 * W;
    localparam longint ONE = longint'(1) << FRAC;

    typedef struct {
        logic [CH*W-1:0] data;
        logic [CH-1:0]   sat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CH*IW-1:0]  in_data = '0;
    logic [1:0]        in_mode = 2'd0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CH*W-1:0]   out_data;
    logic [CH-1:0]     out_sat;
`ifdef ACT_SAT_CNT_EN
    logic              sat_clr = 1'b0;
    logic [15:0]       sat_cnt;
    int                model_cnt = 0;
`endif

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   rand_rdy = 1'b0;

    pwl_act_unit #(.WIDTH(W), .CH(CH), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
`ifdef ACT_SAT_CNT_EN
        ,
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: each function straight from its definition, then clip to 8 bits.
    function automatic void model_lane(input longint x, input int mode,
                                       output logic [W-1:0] r, output logic s);
        longint v;
        case (mode)
            0: begin
                v = (x < 0) ? -x : x;
                if (v < ONE) v = ONE;
            end
            1: v = (x > 0) ? x : 0;
            2: v = (x > ONE) ? ONE : ((x < -ONE) ? -ONE : x);
            default: v = x;
        endcase
        s = 1'b0;
        if (v > 127) begin
            v = 127;
            s = 1'b1;
        end else if (v < -128) begin
            v = -128;
            s = 1'b1;
        end
        r = W'(v);
    endfunction

    function automatic exp_t model_beat(input logic [CH*IW-1:0] d, input int mode);
        exp_t e;
        logic [W-1:0] r;
        logic s;
        logic signed [IW-1:0] xs;
        for (int c = 0; c < CH; c++) begin
            xs = d[c*IW +: IW];
            model_lane(longint'(xs), mode, r, s);
            e.data[c*W +: W] = r;
            e.sat[c] = s;
        end
        return e;
    endfunction

    function automatic logic [CH*IW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {IW'(d), IW'(c), IW'(b), IW'(a)};
    endfunction

    function automatic logic [IW-1:0] rand_sample();
        int v;
        case ($urandom_range(0, 3))
            0: return IW'($urandom);
            1: begin
                v = int'($urandom_range(0, 600)) - 300;
                return IW'(v);
            end
            2: begin
                v = int'($urandom_range(0, 6)) - 3;
                return IW'(v);
            end
            default: begin
                case ($urandom_range(0, 7))
                    0: return 16'h8000;
                    1: return 16'h7FFF;
                    2: return 16'h007F;
                    3: return 16'h0080;
                    4: return 16'hFF80;
                    5: return 16'hFF7F;
                    6: return 16'hFFFF;
                    default: return 16'h0001;
                endcase
            end
        endcase
    endfunction

    function automatic logic [CH*IW-1:0] rand_beat();
        logic [CH*IW-1:0] d;
        for (int c = 0; c < CH; c++) d[c*IW +: IW] = rand_sample();
        return d;
    endfunction

    // Offer one beat until accepted; expected result enters the scoreboard.
    task automatic send(input logic [CH*IW-1:0] d, input int mode);
        logic acc;
        acc = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            in_valid = 1'b1;
            in_data  = d;
            in_mode  = 2'(mode);
            #1;
            acc = in_ready;
            @(posedge clk);
            if (acc) sb.push_back(model_beat(d, mode));
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout in_ready never high");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            #3;
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: samples mid-cycle; a valid&&ready here is the transfer at the next edge.
    logic            stall_prev = 1'b0;
    logic [CH*W-1:0] held_data;
    logic [CH-1:0]   held_sat;
    exp_t            mon_e;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            stall_prev = 1'b0;
`ifdef ACT_SAT_CNT_EN
            model_cnt = 0;
`endif
        end else begin
            if (stall_prev) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(held_data));
                check("stall_sat", 64'(out_sat), 64'(held_sat));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out got=%0h expected=none", out_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_data", 64'(out_data), 64'(mon_e.data));
                    check("out_sat", 64'(out_sat), 64'(mon_e.sat));
                end
            end
`ifdef ACT_SAT_CNT_EN
            if (sat_clr) model_cnt = 0;
            else if (out_valid && out_ready && (|out_sat) && model_cnt < 65535) model_cnt++;
`endif
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_sat   = out_sat;
        end
    end

    initial begin
        int sent;
        int seen;
        logic acc;
        logic need;
        logic [CH*IW-1:0] d;

        // Reset and post-release state.
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef ACT_SAT_CNT_EN
        check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
`endif

        // EQ2 on small values, with exact 2-cycle latency.
        out_ready = 1'b1;
        send(pack4(5, 0, -1, -3), 0);
        @(negedge clk);
        #1;
        check("lat_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        check("lat_cycle2_valid", 64'(out_valid), 64'd1);
        check("eq2_small_data", 64'(out_data), 64'h03010105);
        check("eq2_small_sat", 64'(out_sat), 64'd0);
        drain();

        // Saturation cases, including the most-negative input.
        send(pack4(-300, 300, 0, 2), 0);
        send(pack4(-200, 50, 127, -128), 3);
        send(pack4(-32768, 32767, 128, -129), 0);
        send(pack4(-32768, 32767, 128, -129), 3);
        drain();

        // ReLU and hard-tanh on the same vector.
        send(pack4(-7, 0, 1, 9), 1);
        send(pack4(-7, 0, 1, 9), 2);
        drain();

        // Ten beats, alternating mode, three stalled cycles mid-stream.
        sent = 0;
        need = 1'b1;
        d = '0;
        for (int i = 0; i < 60 && sent < 10; i++) begin
            @(negedge clk);
            out_ready = !(i >= 4 && i < 7);
            if (need) d = rand_beat();
            in_valid = 1'b1;
            in_data  = d;
            in_mode  = (sent % 2 == 1) ? 2'd3 : 2'd0;
            #1;
            acc = in_ready;
            if (i == 5) check("full_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            if (acc) begin
                sb.push_back(model_beat(d, int'(in_mode)));
                sent++;
            end
            need = acc;
            #1;
        end
        in_valid = 1'b0;
        check("stream_sent", 64'(sent), 64'd10);
        drain();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(pack4(1, 2, 3, 4), 1);
        send(pack4(5, 6, 7, 8), 3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_output", 64'(seen), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        send(pack4(-2, 2, 100, -100), 2);
        @(negedge clk);
        #1;
        check("midrst_lat1", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        check("midrst_lat2", 64'(out_valid), 64'd1);
        drain();

        // Random traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int b = 0; b < 300; b++) begin
            send(rand_beat(), int'($urandom_range(0, 3)));
        end
        drain();
        rand_rdy = 1'b0;

`ifdef ACT_SAT_CNT_EN
        check("cnt_after_random", 64'(sat_cnt), 64'(model_cnt));
        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        #1;
        check("cnt_cleared", 64'(sat_cnt), 64'd0);
        for (int k = 0; k < 3; k++) send(pack4(300, 0, 0, 0), 0);
        drain();
        check("cnt_three", 64'(sat_cnt), 64'd3);
        @(negedge clk);
        sat_clr = 1'b1;
        send(pack4(300, 0, 0, 0), 0);
        drain();
        check("cnt_clr_wins", 64'(sat_cnt), 64'd0);
        @(negedge clk);
        sat_clr = 1'b0;
        @(negedge clk);
        #1;
        check("cnt_stays_zero", 64'(sat_cnt), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
